alu_core: RTL and testbench

32-bit integer ALU for the pipelined RV32I datapath's execute stage. It provides a combinational result and Zero flag for the same-cycle branch and forward paths. It also provides a registered copy of both, which feeds the EX/MEM boundary. Operation is selected by a 4-bit code from the ALU control decoder.

---
 rtl/alu_core_if.sv | 52 +++++
 rtl/alu_core.sv | 131 +++++++++++++
 tb/tb_alu_core.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand/result bundle for the RV32I execute-stage ALU.
//
// Signals:
//   En          - register load enable (1 = load, 0 = hold / pipeline stall)
//   SrcA, SrcB  - operands (SrcB[4:0] is the shift amount)
//   Operation   - 4-bit operation select from the ALU control decoder
//   ALUResult   - combinational result
//   Zero        - combinational, 1 when ALUResult == 0
//   ALUResultQ  - registered ALUResult
//   ZeroQ       - registered Zero
//   Carry/Overflow/Negative and their Q copies exist only when ALU_FLAGS_EN
//   is defined.
//
// Transfer rule: there is no valid/ready pair. The combinational outputs
// always reflect the current inputs. The registered outputs capture them on
// every rising clk edge where En is 1, and hold when En is 0.
//
// Modports: master drives operands/control (decoder or bench); slave is the ALU.
interface alu_core_if #(parameter int WIDTH = 32);
  logic             En;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic [WIDTH-1:0] ALUResultQ;
  logic             ZeroQ;
`ifdef ALU_FLAGS_EN
  logic             Carry;
  logic             Overflow;
  logic             Negative;
  logic             CarryQ;
  logic             OverflowQ;
  logic             NegativeQ;
`endif

  modport master (
    output En, SrcA, SrcB, Operation,
    input  ALUResult, Zero, ALUResultQ, ZeroQ
`ifdef ALU_FLAGS_EN
    , input Carry, Overflow, Negative, CarryQ, OverflowQ, NegativeQ
`endif
  );

  modport slave (
    input  En, SrcA, SrcB, Operation,
    output ALUResult, Zero, ALUResultQ, ZeroQ
`ifdef ALU_FLAGS_EN
    , output Carry, Overflow, Negative, CarryQ, OverflowQ, NegativeQ
`endif
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit integer ALU for the pipelined RV32I execute stage.
//
// It produces a combinational result plus a Zero flag for the branch and
// forwarding paths. It also produces a registered copy of both for the
// EX/MEM boundary.
//
// Ports:
//   clk    - rising-edge clock for the output register
//   reset  - asynchronous active-low reset for the output register
//   bus    - alu_core_if.slave (En, SrcA, SrcB, Operation, ALUResult, Zero,
//            ALUResultQ, ZeroQ, plus flag signals when enabled)
//
// Optional feature: define ALU_FLAGS_EN to add the Carry, Overflow and
// Negative outputs and their registered copies. When it is not defined,
// those signals do not exist and the core behaviour is unchanged.
//
// Operation codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLL,
// 1000 SRL, 1001 SLT, 1010 SLTU, 1011 SRA. Every other code gives 0.
module alu_core #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_core_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;

  assign a     = bus.SrcA;
  assign b     = bus.SrcB;
  // Only the low bits select the shift distance; the upper SrcB bits are ignored.
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (bus.Operation)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero          = ~|result;
  assign bus.ALUResult = result;
  assign bus.Zero      = zero;

  // Reset value is 0 with Zero = 1, so ZeroQ always equals (ALUResultQ == 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ALUResultQ <= '0;
      bus.ZeroQ      <= 1'b1;
    end else if (bus.En) begin
      bus.ALUResultQ <= result;
      bus.ZeroQ      <= zero;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           carry;
  logic           overflow;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (bus.Operation)
      OP_ADD: begin
        carry    = sum_ext[WIDTH];
        // Operands share a sign but the sum has the other sign.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extended subtraction borrows out of the top bit when A < B,
        // so carry is the inverted borrow (A >= B unsigned).
        carry    = ~diff_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign bus.Carry    = carry;
  assign bus.Overflow = overflow;
  assign bus.Negative = result[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.CarryQ    <= 1'b0;
      bus.OverflowQ <= 1'b0;
      bus.NegativeQ <= 1'b0;
    end else if (bus.En) begin
      bus.CarryQ    <= carry;
      bus.OverflowQ <= overflow;
      bus.NegativeQ <= result[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector bench for alu_core.
// The driver applies operands and pushes the hand-computed result and zero
// flag onto expected queues. A monitor samples the DUT on every falling clock
// edge and compares the outputs against what was queued.
module tb_alu_core;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];   // {ALUResult, Zero} expected on combinational path
  string       name_q[$];
  logic [32:0] expr_q[$];  // {ALUResultQ, ZeroQ} expected on registered path
  string       namer_q[$];
  int          n_vec;
  int          n_fail;

  // ---------------- driver tasks ----------------
  // Drive one vector shortly after a rising edge; the check happens at the
  // following falling edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic en,
                       input logic [31:0] exp, input string nm);
    @(posedge clk);
    #1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.En        = en;
    exp_q.push_back({exp, (exp == 32'd0)});
    name_q.push_back(nm);
  endtask

  // Queue an expectation for the registered outputs at the next falling edge.
  task automatic expect_reg(input logic [31:0] v, input string nm);
    expr_q.push_back({v, (v == 32'd0)});
    namer_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [32:0] got;
    string       nm;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.ALUResult, bus.Zero};
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                 nm, got[32:1], got[0], e[32:1], e[0]);
      end
    end
    while (expr_q.size() > 0) begin
      e   = expr_q.pop_front();
      nm  = namer_q.pop_front();
      got = {bus.ALUResultQ, bus.ZeroQ};
      n_vec++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got ALUResultQ=%h ZeroQ=%b, expected ALUResultQ=%h ZeroQ=%b",
                 nm, got[32:1], got[0], e[32:1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] A1 = 32'h113C2DE4;
  localparam logic [31:0] B1 = 32'hFB0B4877;
  localparam logic [31:0] A2 = 32'hFB0B4877;

  initial begin
    n_vec         = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.En        = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = 4'b0000;

    // Reset state while reset is held low.
    @(posedge clk);
    #1;
    expect_reg(32'd0, "reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Bitwise and arithmetic, En = 0 so the register stays at reset value.
    apply(4'b0000, A1, B1, 1'b0, 32'h11080864, "and");
    apply(4'b0001, A1, B1, 1'b0, 32'hFB3F6DF7, "or");
    apply(4'b0010, A1, B1, 1'b0, 32'h0C47765B, "add");
    apply(4'b0011, A1, B1, 1'b0, 32'hEA376593, "xor");
    apply(4'b0110, A1, B1, 1'b0, 32'h1630E56D, "sub");
    apply(4'b1001, A1, B1, 1'b0, 32'h00000000, "slt_neg_b");
    apply(4'b1010, A1, B1, 1'b0, 32'h00000001, "sltu");
    apply(4'b1001, B1, A1, 1'b0, 32'h00000001, "slt_neg_a");
    expect_reg(32'd0, "hold_after_release");

    // Shifts; the upper SrcB bits must be ignored.
    apply(4'b0111, A1, 32'h0000000A, 1'b0, 32'hF0B79000, "sll_10");
    apply(4'b1000, A1, 32'h0000000A, 1'b0, 32'h00044F0B, "srl_10");
    apply(4'b0111, A1, 32'hFFFFFFEA, 1'b0, 32'hF0B79000, "sll_hi_bits");
    apply(4'b1000, A1, 32'hFFFFFFEA, 1'b0, 32'h00044F0B, "srl_hi_bits");
    apply(4'b1011, A2, 32'd10, 1'b0, 32'hFFFEC2D2, "sra_10");
    apply(4'b1000, A2, 32'd10, 1'b0, 32'h003EC2D2, "srl_neg_10");
    apply(4'b1011, A2, 32'h00000020, 1'b0, A2, "sra_by_0");
    apply(4'b0111, A1, 32'd0, 1'b0, A1, "sll_by_0");

    // Zero flag and unused codes.
    apply(4'b0110, 32'h12345678, 32'h12345678, 1'b0, 32'd0, "sub_equal");
    apply(4'b1111, A1, B1, 1'b0, 32'd0, "op_1111");
    apply(4'b0100, A1, B1, 1'b0, 32'd0, "op_0100");
    apply(4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'd0, "add_wrap");

    // Register path: load 5+7, then stall with new inputs.
    apply(4'b0010, 32'd5, 32'd7, 1'b1, 32'd12, "add_5_7");
    apply(4'b0110, 32'h12345678, 32'h12345678, 1'b0, 32'd0, "stall_sub");
    expect_reg(32'd12, "load_12");
    apply(4'b0001, A1, B1, 1'b0, 32'hFB3F6DF7, "stall_or");
    expect_reg(32'd12, "hold_12");

    // Reset asserted between edges must clear the register at once.
    @(posedge clk);
    #2;
    reset = 1'b0;
    expect_reg(32'd0, "async_reset_mid");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.En = 1'b0;
    expect_reg(32'd0, "after_reset_hold");

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
